// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM request front-end.
package sdram_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } sdram_q_state_t;

endpackage

// File: rtl/sdram_ctrl_if.sv
// Manager/subordinate port of the SDRAM controller command/completion handshake.
interface sdram_ctrl_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int WORD_LEN   = DATA_WIDTH / 8
);
   logic [WORD_LEN-1:0]   wr;
   logic                  rd;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] write_data;
   logic                  rdy;
   logic                  rvalid;
   logic                  wvalid;
   logic                  error;
   logic [DATA_WIDTH-1:0] read_data;

   modport man (
      output wr, rd, addr, write_data,
      input  rdy, rvalid, wvalid, error, read_data
   );

   modport sub (
      input  wr, rd, addr, write_data,
      output rdy, rvalid, wvalid, error, read_data
   );
endinterface

// File: rtl/sdram_fifo.sv
// Generic synchronous FIFO; pointers carry one extra wrap bit so full and
// empty stay distinguishable when the index bits match.
module sdram_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       pop_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level    = wr_ptr - rd_ptr;
   assign pop_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/sdram_req_queue.sv
// Request queue in front of the SDRAM controller: buffers client requests and
// issues them one at a time, returning completions on a registered response port.
module sdram_req_queue
   import sdram_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int WORD_LEN   = DATA_WIDTH / 8,
   parameter int DEPTH      = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [WORD_LEN-1:0]    req_be,
   input  logic [ADDR_WIDTH-1:0]  req_addr,
   input  logic [DATA_WIDTH-1:0]  req_wdata,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DATA_WIDTH-1:0]  rsp_rdata,
   output logic                   rsp_write,
   output logic                   rsp_error,
   output logic [$clog2(DEPTH):0] level,
   sdram_ctrl_if.man              ctrl
);
   localparam int REQ_W = WORD_LEN + ADDR_WIDTH + DATA_WIDTH;

   sdram_q_state_t        state;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  push;
   logic                  pop;
   logic [REQ_W-1:0]      head;
   logic [WORD_LEN-1:0]   head_be;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic [DATA_WIDTH-1:0] head_wdata;
   logic                  head_read;
   logic                  is_read;
   logic                  done;

   assign req_ready = rst_n && !fifo_full;
   assign push      = req_valid && req_ready;
   // Only pop when the response slot will be free by the time this request completes.
   assign pop       = (state == IDLE) && !fifo_empty && (!rsp_valid || rsp_ready);

   assign {head_be, head_addr, head_wdata} = head;
   assign head_read = (head_be == '0);

   // The strobe for the other transfer type is ignored.
   assign done = (state == WAIT) && (is_read ? ctrl.rvalid : ctrl.wvalid);

   sdram_fifo #(
      .WIDTH (REQ_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data ({req_be, req_addr, req_wdata}),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (level)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= IDLE;
         is_read         <= 1'b0;
         ctrl.wr         <= '0;
         ctrl.rd         <= 1'b0;
         ctrl.addr       <= '0;
         ctrl.write_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  ctrl.addr       <= head_addr;
                  ctrl.wr         <= head_be;
                  ctrl.rd         <= head_read;
                  ctrl.write_data <= head_read ? '0 : head_wdata;
                  is_read         <= head_read;
                  state           <= ISSUE;
               end
            end
            ISSUE: begin
               if (ctrl.rdy) begin
                  ctrl.wr         <= '0;
                  ctrl.rd         <= 1'b0;
                  ctrl.write_data <= '0;
                  state           <= WAIT;
               end
            end
            WAIT: begin
               if (done) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_write <= 1'b0;
         rsp_error <= 1'b0;
      end else if (done) begin
         rsp_valid <= 1'b1;
         rsp_rdata <= is_read ? ctrl.read_data : '0;
         rsp_write <= !is_read;
         rsp_error <= ctrl.error;
      end else if (rsp_valid && rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sdram_req_queue.sv
// Scoreboard bench for sdram_req_queue: a behavioural controller model plus
// queue-based expectations for issue order, completions and occupancy.
module tb_sdram_req_queue;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int WL    = 4;
   localparam int DEPTH = 4;

   typedef struct {
      logic [WL-1:0] be;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } req_t;

   typedef struct {
      logic [DW-1:0] rdata;
      logic          write;
      logic          error;
   } rsp_t;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  req_valid = 1'b0;
   logic                  req_ready;
   logic [WL-1:0]         req_be = '0;
   logic [AW-1:0]         req_addr = '0;
   logic [DW-1:0]         req_wdata = '0;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic                  rsp_rdy_drv = 1'b1;
   logic                  rsp_throttle = 1'b0;
   logic [DW-1:0]         rsp_rdata;
   logic                  rsp_write;
   logic                  rsp_error;
   logic [$clog2(DEPTH):0] level;

   sdram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORD_LEN(WL)) ctrl_bus ();

   assign rsp_ready = rsp_rdy_drv & ~rsp_throttle;

   sdram_req_queue #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .WORD_LEN   (WL),
      .DEPTH      (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_be    (req_be),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_write (rsp_write),
      .rsp_error (rsp_error),
      .level     (level),
      .ctrl      (ctrl_bus)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_pass   = 0;
   req_t exp_issue[$];
   rsp_t exp_rsp[$];

   // controller-model knobs, written only by the main sequence
   bit            stall   = 1'b0;
   bit            noise   = 1'b0;
   bit            spur_en = 1'b0;
   bit            fix_en  = 1'b0;
   logic [DW-1:0] fix_data = '0;
   bit            fix_err = 1'b0;
   int            lat     = 1;
   int            inj_req = 0;
   // written only by the controller model
   int            inj_ack = 0;
   int            acc_count = 0;
   int            act_cycles = 0;
   int            last_act = 0;
   // written only by the monitor
   int            n_push = 0;
   int            n_pop  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic fail(input string name, input string why);
      n_checks++;
      $display("FAIL %s: %s (t=%0t)", name, why, $time);
   endtask

   // Controller model: acts at negedge+1, checks issued commands against the
   // oldest accepted request and schedules the completion strobe.
   initial begin : ctrl_model
      int            cnt;
      bit            outst;
      bit            cur_read;
      logic [DW-1:0] cur_d;
      logic          cur_e;
      bit            active;
      req_t          r;
      rsp_t          e;
      cnt = 0; outst = 1'b0; cur_read = 1'b0; cur_d = '0; cur_e = 1'b0;
      ctrl_bus.rdy = 1'b0; ctrl_bus.rvalid = 1'b0; ctrl_bus.wvalid = 1'b0;
      ctrl_bus.error = 1'b0; ctrl_bus.read_data = '0;
      forever begin
         @(negedge clk); #1;
         ctrl_bus.rvalid    = 1'b0;
         ctrl_bus.wvalid    = 1'b0;
         ctrl_bus.error     = ($urandom_range(0, 1) != 0);
         ctrl_bus.read_data = $urandom;
         rsp_throttle       = noise && ($urandom_range(0, 3) == 0);
         ctrl_bus.rdy       = !stall && !(noise && ($urandom_range(0, 2) == 0));
         if (!rst_n) begin
            outst = 1'b0; cnt = 0; act_cycles = 0;
            continue;
         end
         active = ctrl_bus.rd || (ctrl_bus.wr != '0);
         if (outst) begin
            chk("wait_ctrl_cleared", 64'({ctrl_bus.rd, ctrl_bus.wr, ctrl_bus.write_data}), 64'(0));
            cnt--;
            if (cnt == 0) begin
               if (cur_read) ctrl_bus.rvalid = 1'b1;
               else          ctrl_bus.wvalid = 1'b1;
               ctrl_bus.read_data = cur_d;
               ctrl_bus.error     = cur_e;
               outst = 1'b0;
            end else if (spur_en) begin
               if (cur_read) ctrl_bus.wvalid = 1'b1;
               else          ctrl_bus.rvalid = 1'b1;
            end
         end else if (active) begin
            act_cycles++;
            if (exp_issue.size() == 0) fail("issue_unexpected", "command with no queued request");
            else begin
               r = exp_issue[0];
               chk("issue_addr",  64'(ctrl_bus.addr), 64'(r.addr));
               chk("issue_wr",    64'(ctrl_bus.wr), 64'(r.be));
               chk("issue_rd",    64'(ctrl_bus.rd), 64'(r.be == '0));
               chk("issue_wdata", 64'(ctrl_bus.write_data), (r.be == '0) ? 64'(0) : 64'(r.wdata));
               if (ctrl_bus.rdy) begin
                  void'(exp_issue.pop_front());
                  acc_count++;
                  last_act   = act_cycles;
                  act_cycles = 0;
                  cur_read   = (r.be == '0);
                  cur_d      = fix_en ? fix_data : $urandom;
                  cur_e      = fix_en ? fix_err : ($urandom_range(0, 1) != 0);
                  e.rdata    = cur_read ? cur_d : '0;
                  e.write    = !cur_read;
                  e.error    = cur_e;
                  exp_rsp.push_back(e);
                  outst = 1'b1;
                  cnt   = lat;
               end
            end
         end else if (inj_req != inj_ack) begin
            ctrl_bus.rvalid = 1'b1;
            inj_ack++;
         end else if (spur_en && ($urandom_range(0, 3) == 0)) begin
            if ($urandom_range(0, 1) != 0) ctrl_bus.rvalid = 1'b1;
            else                           ctrl_bus.wvalid = 1'b1;
         end
      end
   end

   // Monitor: samples at negedge+2, when everything the next edge will see is settled.
   initial begin : monitor
      bit   prev_act;
      bit   act;
      req_t r;
      rsp_t e;
      prev_act = 1'b0;
      forever begin
         @(negedge clk); #2;
         if (!rst_n) begin
            chk("reset_req_ready", 64'(req_ready), 64'(0));
            exp_issue.delete(); exp_rsp.delete();
            n_push = 0; n_pop = 0; prev_act = 1'b0;
            continue;
         end
         act = ctrl_bus.rd || (ctrl_bus.wr != '0);
         if (act && !prev_act) n_pop++;
         prev_act = act;
         chk("level", 64'(level), 64'(n_push - n_pop));
         chk("req_ready", 64'(req_ready), 64'((n_push - n_pop) < DEPTH));
         if (req_valid && req_ready) begin
            r.be = req_be; r.addr = req_addr; r.wdata = req_wdata;
            exp_issue.push_back(r);
            n_push++;
         end
         if (rsp_valid) begin
            if (exp_rsp.size() == 0) fail("rsp_unexpected", "response with nothing outstanding");
            else begin
               e = exp_rsp[0];
               chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
               chk("rsp_write", 64'(rsp_write), 64'(e.write));
               chk("rsp_error", 64'(rsp_error), 64'(e.error));
               if (rsp_ready) void'(exp_rsp.pop_front());
            end
         end
      end
   end

   task automatic push_req(input logic [WL-1:0] be, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input int lim, output bit ok);
      req_valid = 1'b1; req_be = be; req_addr = a; req_wdata = d; ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         if (req_ready) ok = 1'b1;
         @(negedge clk);
         if (ok) break;
      end
      req_valid = 1'b0;
   endtask

   task automatic drain(input string name, input int lim);
      int i;
      i = 0;
      while ((exp_issue.size() != 0 || exp_rsp.size() != 0 || rsp_valid) && i < lim) begin
         @(negedge clk);
         i++;
      end
      if (i >= lim) fail(name, "timed out waiting for completions");
   endtask

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : main
      bit ok;
      int base;
      int i;

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_ctrl_rd",    64'(ctrl_bus.rd), 64'(0));
      chk("reset_ctrl_wr",    64'(ctrl_bus.wr), 64'(0));
      chk("reset_ctrl_addr",  64'(ctrl_bus.addr), 64'(0));
      chk("reset_ctrl_wdata", 64'(ctrl_bus.write_data), 64'(0));
      chk("reset_rsp_valid",  64'(rsp_valid), 64'(0));
      chk("reset_rsp_rdata",  64'(rsp_rdata), 64'(0));
      chk("reset_rsp_write",  64'(rsp_write), 64'(0));
      chk("reset_rsp_error",  64'(rsp_error), 64'(0));
      chk("reset_level",      64'(level), 64'(0));
      chk("reset_ready_low",  64'(req_ready), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);
      chk("release_ready", 64'(req_ready), 64'(1));

      // single read, rdy already high, completion 3 cycles after acceptance
      fix_en = 1'b1; fix_data = 32'hDEADBEEF; fix_err = 1'b0; lat = 3;
      push_req(4'b0000, 32'h100, 32'h0, 10, ok);
      chk("t1_push", 64'(ok), 64'(1));
      drain("t1_drain", 50);
      chk("t1_rd_cycles", 64'(last_act), 64'(1));

      // write held in ISSUE by rdy low for five cycles
      fix_en = 1'b0; lat = 2; stall = 1'b1;
      push_req(4'b0011, 32'h104, 32'h12345678, 10, ok);
      chk("t2_push", 64'(ok), 64'(1));
      repeat (6) @(negedge clk);
      stall = 1'b0;
      drain("t2_drain", 50);
      chk("t2_issue_cycles", 64'(last_act), 64'(6));

      // fill while stalled: one request sits in the issue register, four in the FIFO
      stall = 1'b1;
      for (int k = 0; k < 5; k++) begin
         push_req((k % 2 == 0) ? 4'b0000 : 4'b1111, 32'h200 + 32'(4 * k), $urandom, 10, ok);
         chk("t3_push", 64'(ok), 64'(1));
      end
      chk("t3_level_full", 64'(level), 64'(DEPTH));
      chk("t3_ready_low", 64'(req_ready), 64'(0));
      push_req(4'b0000, 32'h214, 32'h0, 5, ok);
      chk("t3_full_refuses", 64'(ok), 64'(0));
      stall = 1'b0;
      push_req(4'b0000, 32'h214, 32'h0, 30, ok);
      chk("t3_push_after_release", 64'(ok), 64'(1));
      drain("t3_drain", 200);

      // response held: no second issue until it is taken
      rsp_rdy_drv = 1'b0; base = acc_count; lat = 2;
      for (int k = 0; k < 3; k++) begin
         push_req(4'b0000, 32'h300 + 32'(4 * k), 32'h0, 10, ok);
         chk("t4_push", 64'(ok), 64'(1));
      end
      repeat (10) @(negedge clk);
      chk("t4_single_issue", 64'(acc_count - base), 64'(1));
      chk("t4_rsp_held", 64'(rsp_valid), 64'(1));
      chk("t4_level", 64'(level), 64'(2));
      rsp_rdy_drv = 1'b1;
      drain("t4_drain", 100);

      // rvalid in IDLE is dropped; error captured; spurious wvalid during read WAIT ignored
      inj_req++;
      repeat (4) @(negedge clk);
      chk("t5_idle_rvalid_dropped", 64'(rsp_valid), 64'(0));
      fix_en = 1'b1; fix_data = 32'hCAFE0001; fix_err = 1'b1; lat = 4; spur_en = 1'b1;
      push_req(4'b0000, 32'h400, 32'h0, 10, ok);
      chk("t5_push", 64'(ok), 64'(1));
      drain("t5_drain", 50);
      spur_en = 1'b0; fix_en = 1'b0;

      // reset while waiting for a completion; the late rvalid must be dropped
      lat = 30; base = acc_count;
      push_req(4'b0000, 32'h500, 32'h0, 10, ok);
      chk("t6_push", 64'(ok), 64'(1));
      i = 0;
      while (acc_count == base && i < 20) begin
         @(negedge clk);
         i++;
      end
      if (i >= 20) fail("t6_accept", "request never accepted");
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      inj_req++;
      repeat (4) @(negedge clk);
      chk("t6_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("t6_level", 64'(level), 64'(0));
      chk("t6_ready", 64'(req_ready), 64'(1));

      // randomized traffic with controller and client back-pressure and stray strobes
      noise = 1'b1; spur_en = 1'b1;
      for (int k = 0; k < 80; k++) begin
         lat = int'($urandom_range(1, 4));
         push_req(($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(1, 15)),
                  $urandom & 32'hFFFF_FFFC, $urandom, 200, ok);
         chk("rand_push", 64'(ok), 64'(1));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      noise = 1'b0; spur_en = 1'b0;
      drain("rand_drain", 2000);
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
